sd_req_arbiter: RTL and testbench

Shares the core-side sector interface of the SD card wrapper (rstart/wstart/rsector/rdone plus the sector byte stream) between up to four core requesters (2x floppy, 2x ACSI). Round-robin selection; holds one one-hot start request to the wrapper until rdone. Routes read-data strobes to the granted requester and write data from it. Sits between the core's disk controllers and the SD card wrapper.

---
 rtl/sd_req_arbiter.sv | 249 ++++++++++++++++++++++++
 tb/tb_sd_req_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sd_req_arbiter
// Purpose  : Round-robin sharing of the SD wrapper sector port among up to four
//            core requesters. Define SD_ARB_TIMEOUT_EN for the ISSUE watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module sd_req_arbiter #(
    parameter int          NUM_REQ        = 4,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd12000000
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NUM_REQ-1:0]    req_rd,
    input  logic [NUM_REQ-1:0]    req_wr,
    input  logic [32*NUM_REQ-1:0] req_sector,
    input  logic [8*NUM_REQ-1:0]  req_inbyte,
    output logic [NUM_REQ-1:0]    req_busy,
    output logic [NUM_REQ-1:0]    req_done,
    output logic [NUM_REQ-1:0]    req_err,
    output logic [NUM_REQ-1:0]    req_outen,
    output logic [8:0]            req_outaddr,
    output logic [7:0]            req_outbyte,
    output logic [3:0]            sd_rstart,
    output logic [3:0]            sd_wstart,
    output logic [31:0]           sd_rsector,
    input  logic                  sd_rbusy,
    input  logic                  sd_rdone,
    input  logic                  sd_outen,
    input  logic [8:0]            sd_outaddr,
    input  logic [7:0]            sd_outbyte,
    output logic [7:0]            sd_inbyte
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] c_last_init = 2'(NUM_REQ - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_gnt;
    logic [1:0]  w_gnt_nxt;
    logic        r_rd;
    logic        w_rd_nxt;
    logic [1:0]  r_last;
    logic [1:0]  w_last_nxt;
    logic [31:0] r_sector;
    logic [31:0] w_sector_nxt;
    logic [3:0]  r_busy;
    logic [3:0]  w_busy_nxt;
    logic [3:0]  r_done;
    logic [3:0]  w_done_nxt;
    logic [3:0]  r_rstart;
    logic [3:0]  w_rstart_nxt;
    logic [3:0]  r_wstart;
    logic [3:0]  w_wstart_nxt;
    logic [3:0]  r_prev;
    logic [3:0]  r_pending;
    logic [3:0]  w_pending_nxt;
    logic [3:0]  w_lvl;
    logic [3:0]  w_rd_req;
    logic [3:0]  w_rise;
    logic [3:0]  w_clr;
    logic [31:0] w_sector [4];
    logic [7:0]  w_inbyte [4];
    logic        w_found;
    logic [1:0]  w_pick;
    logic [3:0]  w_pick_oh;
    logic [3:0]  w_gnt_oh;
    logic        w_release;
    logic [3:0]  w_outen4;

    // Requester slots are padded to four so all internal vectors keep one width.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slot
            if (gi < NUM_REQ) begin : g_used
                assign w_sector[gi] = req_sector[gi*32 +: 32];
                assign w_inbyte[gi] = req_inbyte[gi*8 +: 8];
                assign w_rd_req[gi] = req_rd[gi];
                assign w_lvl[gi]    = req_rd[gi] | req_wr[gi];
            end else begin : g_unused
                assign w_sector[gi] = 32'h0;
                assign w_inbyte[gi] = 8'h0;
                assign w_rd_req[gi] = 1'b0;
                assign w_lvl[gi]    = 1'b0;
            end
        end
    endgenerate

    assign w_rise    = w_lvl & ~r_prev;
    assign w_pick_oh = 4'b0001 << w_pick;
    assign w_gnt_oh  = 4'b0001 << r_gnt;

    function automatic logic [1:0] wrap_idx(input logic [1:0] base, input int step);
        int s;
        s = int'(base) + step;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return s[1:0];
    endfunction

    // First pending slot after the last one served, wrapping around.
    always_comb begin : p_arb
        w_found = 1'b0;
        w_pick  = 2'd0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_found && r_pending[wrap_idx(r_last, k)]) begin
                w_found = 1'b1;
                w_pick  = wrap_idx(r_last, k);
            end
        end
    end

`ifdef SD_ARB_TIMEOUT_EN
    logic [23:0] r_tmo_cnt;
    logic [3:0]  r_err;
    logic [3:0]  w_err_nxt;
    logic        w_tmo_hit;

    always_ff @(posedge clk or negedge rstn) begin : p_tmo
        if (!rstn) begin
            r_tmo_cnt <= 24'd0;
        end else if (r_state != ST_ISSUE) begin
            r_tmo_cnt <= 24'd0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 24'd1;
        end
    end

    assign w_tmo_hit = (r_state == ST_ISSUE) && (r_tmo_cnt == TIMEOUT_CYCLES - 24'd1);
    assign req_err   = r_err[NUM_REQ-1:0];
`else
    logic w_unused_tmo;
    assign w_unused_tmo = ^TIMEOUT_CYCLES;
    assign req_err      = '0;
`endif

    always_comb begin : p_next
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_rd_nxt     = r_rd;
        w_last_nxt   = r_last;
        w_sector_nxt = r_sector;
        w_busy_nxt   = r_busy;
        w_rstart_nxt = r_rstart;
        w_wstart_nxt = r_wstart;
        w_done_nxt   = 4'b0;
        w_clr        = 4'b0;
        w_release    = sd_rdone;
`ifdef SD_ARB_TIMEOUT_EN
        w_err_nxt    = 4'b0;
        w_release    = sd_rdone | w_tmo_hit;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_found && !sd_rbusy) begin
                    w_gnt_nxt    = w_pick;
                    w_rd_nxt     = w_rd_req[w_pick];
                    w_sector_nxt = w_sector[w_pick];
                    w_busy_nxt   = w_pick_oh;
                    if (w_rd_req[w_pick]) begin
                        w_rstart_nxt = w_pick_oh;
                    end else begin
                        w_wstart_nxt = w_pick_oh;
                    end
                    w_state_nxt  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_release) begin
                    w_clr        = w_gnt_oh;
                    w_last_nxt   = r_gnt;
                    w_busy_nxt   = 4'b0;
                    w_rstart_nxt = 4'b0;
                    w_wstart_nxt = 4'b0;
                    w_state_nxt  = ST_DONE;
                    // A done arriving on the timeout cycle wins over the error.
                    if (sd_rdone) begin
                        w_done_nxt = w_gnt_oh;
                    end
`ifdef SD_ARB_TIMEOUT_EN
                    else begin
                        w_err_nxt = w_gnt_oh;
                    end
`endif
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // A fresh edge on the slot being released must not be lost.
        w_pending_nxt = (r_pending & ~w_clr) | w_rise;
    end

    always_ff @(posedge clk or negedge rstn) begin : p_regs
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_gnt     <= 2'd0;
            r_rd      <= 1'b0;
            r_last    <= c_last_init;
            r_sector  <= 32'h0;
            r_busy    <= 4'b0;
            r_done    <= 4'b0;
            r_rstart  <= 4'b0;
            r_wstart  <= 4'b0;
            r_prev    <= 4'b0;
            r_pending <= 4'b0;
`ifdef SD_ARB_TIMEOUT_EN
            r_err     <= 4'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_rd      <= w_rd_nxt;
            r_last    <= w_last_nxt;
            r_sector  <= w_sector_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_rstart  <= w_rstart_nxt;
            r_wstart  <= w_wstart_nxt;
            r_prev    <= w_lvl;
            r_pending <= w_pending_nxt;
`ifdef SD_ARB_TIMEOUT_EN
            r_err     <= w_err_nxt;
`endif
        end
    end

    assign w_outen4    = (sd_outen && r_rd && (r_state == ST_ISSUE)) ? w_gnt_oh : 4'b0;

    assign req_busy    = r_busy[NUM_REQ-1:0];
    assign req_done    = r_done[NUM_REQ-1:0];
    assign req_outen   = w_outen4[NUM_REQ-1:0];
    assign req_outaddr = sd_outaddr;
    assign req_outbyte = sd_outbyte;
    assign sd_rstart   = r_rstart;
    assign sd_wstart   = r_wstart;
    assign sd_rsector  = r_sector;
    assign sd_inbyte   = (r_state == ST_IDLE) ? 8'h00 : w_inbyte[r_gnt];

endmodule
`default_nettype wire

// File: tb/tb_sd_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_req_arbiter
// Purpose  : Directed self-checking bench for sd_req_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_req_arbiter;

    logic         clk = 1'b0;
    logic         rstn;
    logic [3:0]   req_rd;
    logic [3:0]   req_wr;
    logic [127:0] req_sector;
    logic [31:0]  req_inbyte;
    logic [3:0]   req_busy;
    logic [3:0]   req_done;
    logic [3:0]   req_err;
    logic [3:0]   req_outen;
    logic [8:0]   req_outaddr;
    logic [7:0]   req_outbyte;
    logic [3:0]   sd_rstart;
    logic [3:0]   sd_wstart;
    logic [31:0]  sd_rsector;
    logic         sd_rbusy;
    logic         sd_rdone;
    logic         sd_outen;
    logic [8:0]   sd_outaddr;
    logic [7:0]   sd_outbyte;
    logic [7:0]   sd_inbyte;

    int n_chk  = 0;
    int n_pass = 0;
    int n_hit;
    int n_other;
    int n_addr;
    int n_spur;

    sd_req_arbiter #(
        .NUM_REQ        (4),
        .TIMEOUT_CYCLES (24'd100)
    ) u_dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_rd      (req_rd),
        .req_wr      (req_wr),
        .req_sector  (req_sector),
        .req_inbyte  (req_inbyte),
        .req_busy    (req_busy),
        .req_done    (req_done),
        .req_err     (req_err),
        .req_outen   (req_outen),
        .req_outaddr (req_outaddr),
        .req_outbyte (req_outbyte),
        .sd_rstart   (sd_rstart),
        .sd_wstart   (sd_wstart),
        .sd_rsector  (sd_rsector),
        .sd_rbusy    (sd_rbusy),
        .sd_rdone    (sd_rdone),
        .sd_outen    (sd_outen),
        .sd_outaddr  (sd_outaddr),
        .sd_outbyte  (sd_outbyte),
        .sd_inbyte   (sd_inbyte)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_rdone();
        sd_rdone = 1'b1;
        tick();
        sd_rdone = 1'b0;
    endtask

    task automatic do_reset();
        rstn       = 1'b0;
        req_rd     = 4'b0;
        req_wr     = 4'b0;
        req_sector = '0;
        req_inbyte = '0;
        sd_rbusy   = 1'b0;
        sd_rdone   = 1'b0;
        sd_outen   = 1'b0;
        sd_outaddr = 9'd0;
        sd_outbyte = 8'd0;
        tick(2);
        rstn = 1'b1;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        chk("rst_rstart", sd_rstart, 32'h0);
        chk("rst_wstart", sd_wstart, 32'h0);
        chk("rst_sector", sd_rsector, 32'h0);
        chk("rst_busy", req_busy, 32'h0);
        chk("rst_done", req_done, 32'h0);
        chk("rst_err", req_err, 32'h0);
        chk("rst_inbyte", sd_inbyte, 32'h0);
        pulse_rdone();
        chk("idle_rdone_done", req_done, 32'h0);

        // Slots 0 and 2 rise together; slot 0 re-arms while slot 2 is served.
        req_rd = 4'b0101;
        tick();
        chk("rr_pend_cycle", sd_rstart, 32'h0);
        tick();
        chk("rr_first", sd_rstart, 32'h1);
        chk("rr_busy0", req_busy, 32'h1);
        tick(5);
        pulse_rdone();
        chk("rr_done0", req_done, 32'h1);
        chk("rr_done0_start", sd_rstart, 32'h0);
        req_rd[0] = 1'b0;
        tick();
        chk("rr_gap", sd_rstart, 32'h0);
        chk("rr_done_width", req_done, 32'h0);
        tick();
        chk("rr_second", sd_rstart, 32'h4);
        tick(3);
        req_rd[0] = 1'b1;
        tick(3);
        chk("rr_no_preempt", sd_rstart, 32'h4);
        pulse_rdone();
        chk("rr_done2", req_done, 32'h4);
        tick(2);
        chk("rr_third", sd_rstart, 32'h1);
        pulse_rdone();
        chk("rr_done0b", req_done, 32'h1);
        req_rd = 4'b0;
        tick(2);

        // Slot 1 read with a long wrapper access.
        req_sector[63:32] = 32'h0000_1234;
        req_rd[1] = 1'b1;
        tick();
        chk("r1_n1", sd_rstart, 32'h0);
        tick();
        chk("r1_n2", sd_rstart, 32'h2);
        chk("r1_wstart", sd_wstart, 32'h0);
        chk("r1_sector", sd_rsector, 32'h0000_1234);
        tick(598);
        chk("r1_hold", sd_rstart, 32'h2);
        pulse_rdone();
        chk("r1_done", req_done, 32'h2);
        chk("r1_done_start", sd_rstart, 32'h0);
        chk("r1_done_busy", req_busy, 32'h0);
        tick(4);
        chk("r1_no_rearm", {sd_rstart, sd_wstart}, 32'h0);
        req_rd[1] = 1'b0;
        tick(2);

        // Slot 3 write, held off by a busy wrapper, dropping its request mid-access.
        sd_rbusy = 1'b1;
        req_wr[3] = 1'b1;
        req_inbyte[31:24] = 8'hA5;
        req_sector[127:96] = 32'hDEAD_0003;
        tick(4);
        chk("busy_hold", {sd_rstart, sd_wstart}, 32'h0);
        sd_rbusy = 1'b0;
        tick();
        chk("w3_wstart", sd_wstart, 32'h8);
        chk("w3_rstart", sd_rstart, 32'h0);
        chk("w3_sector", sd_rsector, 32'hDEAD_0003);
        chk("w3_inbyte", sd_inbyte, 32'hA5);
        req_inbyte[31:24] = 8'h3C;
        req_inbyte[7:0] = 8'hFF;
        #1;
        chk("w3_inbyte_track", sd_inbyte, 32'h3C);
        sd_outen = 1'b1;
        sd_outaddr = 9'd7;
        #1;
        chk("w3_outen", req_outen, 32'h0);
        chk("w3_outaddr", req_outaddr, 32'h7);
        tick();
        sd_outen = 1'b0;
        req_wr[3] = 1'b0;
        tick(3);
        chk("w3_drop_hold", sd_wstart, 32'h8);
        pulse_rdone();
        chk("w3_done", req_done, 32'h8);
        tick();
        chk("w3_idle_inbyte", sd_inbyte, 32'h0);
        tick();

        // Slot 2 read with a full 512-byte sector stream.
        req_rd[2] = 1'b1;
        tick(2);
        chk("rd2_start", sd_rstart, 32'h4);
        n_hit = 0;
        n_other = 0;
        n_addr = 0;
        for (int a = 0; a < 512; a++) begin
            sd_outen   = 1'b1;
            sd_outaddr = 9'(a);
            sd_outbyte = 8'(a) ^ 8'h5A;
            #1;
            if (req_outen == 4'b0100) n_hit++;
            else n_other++;
            if (req_outaddr != 9'(a) || req_outbyte != (8'(a) ^ 8'h5A)) n_addr++;
            tick();
            sd_outen = 1'b0;
            #1;
            if (req_outen != 4'b0) n_other++;
            tick();
        end
        chk("rd2_strobes", n_hit, 32'd512);
        chk("rd2_other", n_other, 32'd0);
        chk("rd2_addr", n_addr, 32'd0);
        pulse_rdone();
        chk("rd2_done", req_done, 32'h4);
        req_rd = 4'b0;
        tick(2);

        // Asynchronous reset in the middle of an access.
        req_rd[1] = 1'b1;
        tick(2);
        chk("arst_pre", sd_rstart, 32'h2);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_start", sd_rstart, 32'h0);
        chk("arst_busy", req_busy, 32'h0);
        req_rd[1] = 1'b0;
        tick(2);
        rstn = 1'b1;
        n_spur = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if ((sd_rstart | sd_wstart) != 4'b0) n_spur++;
        end
        chk("arst_no_grant", n_spur, 32'd0);
        req_rd[1] = 1'b1;
        tick(2);
        chk("arst_regrant", sd_rstart, 32'h2);
        pulse_rdone();
        chk("arst_done", req_done, 32'h2);
        req_rd = 4'b0;
        tick(2);

`ifdef SD_ARB_TIMEOUT_EN
        req_rd[0] = 1'b1;
        tick(2);
        chk("tmo_start", sd_rstart, 32'h1);
        sd_rbusy = 1'b1;
        req_rd[1] = 1'b1;
        tick(99);
        chk("tmo_c100_start", sd_rstart, 32'h1);
        chk("tmo_c100_err", req_err, 32'h0);
        tick();
        chk("tmo_err", req_err, 32'h1);
        chk("tmo_no_done", req_done, 32'h0);
        chk("tmo_start_drop", sd_rstart, 32'h0);
        tick(5);
        chk("tmo_wait_busy", sd_rstart, 32'h0);
        sd_rbusy = 1'b0;
        tick();
        chk("tmo_next", sd_rstart, 32'h2);
        pulse_rdone();
        chk("tmo_next_done", req_done, 32'h2);
        req_rd = 4'b0;
        tick(2);
`else
        chk("err_tied", req_err, 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
